// File: rtl/count_down_arbiter.sv
// Shares one WIDTH-bit count-to-zero timer between NREQ requesters.
// Optional build macro FIXED_PRIORITY_EN selects fixed (lowest index wins) arbitration instead of round-robin.
module count_down_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] load_val,
  input  logic                  pause,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic [NREQ-1:0]       done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_n;
  logic [NREQ-1:0]  grant_n;
  logic [WIDTH-1:0] count_n;
  logic [IW-1:0]    owner, owner_n;
  logic [IW-1:0]    win;
  logic             found;
  logic [WIDTH-1:0] lv [NREQ];

`ifndef FIXED_PRIORITY_EN
  logic [IW-1:0]    last, last_n;
  int               rr_idx;
`endif

  // Unpack per-requester load values
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      lv[k] = load_val[k*WIDTH +: WIDTH];
    end
  end

  // Winner selection among pending requests
  always_comb begin
    found = 1'b0;
    win   = '0;
`ifdef FIXED_PRIORITY_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[IW'(k)]) begin
        found = 1'b1;
        win   = IW'(k);
      end
    end
`else
    rr_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = int'(last) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      if (!found && req[IW'(rr_idx)]) begin
        found = 1'b1;
        win   = IW'(rr_idx);
      end
    end
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n = state;
    grant_n = grant;
    count_n = count;
    owner_n = owner;
`ifndef FIXED_PRIORITY_EN
    last_n  = last;
`endif
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_n = NREQ'(1) << win;
          count_n = lv[win];
          owner_n = win;
`ifndef FIXED_PRIORITY_EN
          last_n  = win;
`endif
          state_n = (lv[win] == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!req[owner]) begin
          state_n = S_IDLE;
          grant_n = '0;
          count_n = '0;
        end else if (!pause) begin
          if (count != '0) count_n = count - WIDTH'(1);
          if (count <= WIDTH'(1)) state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        grant_n = '0;
      end
      default: begin
        state_n = S_IDLE;
        grant_n = '0;
        count_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      grant <= '0;
      count <= '0;
      owner <= '0;
`ifndef FIXED_PRIORITY_EN
      last  <= IW'(NREQ - 1);
`endif
    end else begin
      state <= state_n;
      grant <= grant_n;
      count <= count_n;
      owner <= owner_n;
`ifndef FIXED_PRIORITY_EN
      last  <= last_n;
`endif
    end
  end

  // Status decodes straight from registered state
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE) ? grant : '0;

endmodule

// File: tb/tb_count_down_arbiter.sv
// Self-checking bench for count_down_arbiter (NREQ=2, WIDTH=4); honours FIXED_PRIORITY_EN when defined.
module tb_count_down_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] load_val;
  logic                  pause;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic [NREQ-1:0]       done;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  count_down_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req(req), .load_val(load_val), .pause(pause),
    .grant(grant), .count(count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: current owner (-1 when idle), remaining count, done-cycle flag
  int         m_owner = -1;
  int         m_last  = NREQ - 1;
  logic [3:0] m_count = 4'd0;
  bit         m_done  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1;
      m_last  = NREQ - 1;
      m_count = 4'd0;
      m_done  = 0;
    end else if (m_done) begin
      m_done  = 0;
      m_owner = -1;
    end else if (m_owner < 0) begin
      int w;
      w = -1;
`ifdef FIXED_PRIORITY_EN
      for (int i = NREQ - 1; i >= 0; i--) if (req[i]) w = i;
`else
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_last + k) % NREQ;
        if (w < 0 && req[i]) w = i;
      end
`endif
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_count = load_val[w*WIDTH +: WIDTH];
        m_done  = (m_count == 0);
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
      m_count = 4'd0;
    end else if (!pause) begin
      m_count = m_count - 4'd1;
      if (m_count == 0) m_done = 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] eg;
      eg = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
      chk("model_grant", 32'(grant), 32'(eg));
      chk("model_count", 32'(count), 32'(m_count));
      chk("model_busy", 32'(busy), 32'(m_owner >= 0));
      chk("model_done", 32'(done), m_done ? 32'(eg) : 32'd0);
      chk("onehot", 32'($countones(grant) > 1 || $countones(done) > 1), 32'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_o(input string nm, input logic [1:0] g, input logic [3:0] c,
                          input logic b, input logic [1:0] d);
    chk({nm, "_grant"}, 32'(grant), 32'(g));
    chk({nm, "_count"}, 32'(count), 32'(c));
    chk({nm, "_busy"},  32'(busy),  32'(b));
    chk({nm, "_done"},  32'(done),  32'(d));
  endtask

  initial begin
    int lat;
    reset = 1'b0; req = '0; load_val = '0; pause = 1'b0;
    #1 reset = 1'b1;
    chk_en = 1;
    tick(); tick();
    expect_o("reset", 2'b00, 4'd0, 1'b0, 2'b00);
    reset = 1'b0;

    // Reset mid-run at count 7
    req = 2'b01; load_val = 8'h09;
    tick(); tick(); tick();
    expect_o("pre_reset", 2'b01, 4'd7, 1'b1, 2'b00);
    #2 reset = 1'b1;
    #1 expect_o("async_reset", 2'b00, 4'd0, 1'b0, 2'b00);
    tick();
    reset = 1'b0;

    // Two contenders, values 3 and 2
    req = 2'b11; load_val = 8'h23;
    tick(); expect_o("rr_first", 2'b01, 4'd3, 1'b1, 2'b00);
    tick(); tick(); tick();
    expect_o("rr_done0", 2'b01, 4'd0, 1'b1, 2'b01);
    tick(); expect_o("rr_idle0", 2'b00, 4'd0, 1'b0, 2'b00);
    tick();
`ifdef FIXED_PRIORITY_EN
    expect_o("fp_again", 2'b01, 4'd3, 1'b1, 2'b00);
`else
    expect_o("rr_second", 2'b10, 4'd2, 1'b1, 2'b00);
    tick(); tick();
    expect_o("rr_done1", 2'b10, 4'd0, 1'b1, 2'b10);
    tick(); expect_o("rr_idle1", 2'b00, 4'd0, 1'b0, 2'b00);
    tick(); expect_o("rr_third", 2'b01, 4'd3, 1'b1, 2'b00);
`endif
    req = 2'b00;
    tick(); expect_o("rr_abort", 2'b00, 4'd0, 1'b0, 2'b00);

    // Single run of 5
    req = 2'b01; load_val = 8'h05;
    tick();
    for (int i = 5; i >= 0; i--) begin
      expect_o("run5", 2'b01, 4'(i), 1'b1, (i == 0) ? 2'b01 : 2'b00);
      if (i > 0) tick();
    end
    req = 2'b00;
    tick(); expect_o("run5_end", 2'b00, 4'd0, 1'b0, 2'b00);

    // Pause for three cycles at count 2
    req = 2'b01; load_val = 8'h04;
    tick(); lat = 0;
    expect_o("pause_grant", 2'b01, 4'd4, 1'b1, 2'b00);
    tick(); tick(); lat += 2;
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); lat++;
      expect_o("paused", 2'b01, 4'd2, 1'b1, 2'b00);
    end
    pause = 1'b0;
    for (int i = 0; i < 10 && done != 2'b01; i++) begin
      tick(); lat++;
    end
    chk("pause_latency", 32'(lat), 32'd7);
    expect_o("pause_done", 2'b01, 4'd0, 1'b1, 2'b01);
    req = 2'b00;
    tick(); expect_o("pause_end", 2'b00, 4'd0, 1'b0, 2'b00);

    // Zero load: done with grant in the first owned cycle
    req = 2'b10; load_val = 8'h00;
    tick(); expect_o("zero_done", 2'b10, 4'd0, 1'b1, 2'b10);
    req = 2'b00;
    tick(); expect_o("zero_end", 2'b00, 4'd0, 1'b0, 2'b00);

    // Abort at count 6
    req = 2'b01; load_val = 8'h09;
    tick(); tick(); tick(); tick();
    expect_o("abort_pre", 2'b01, 4'd6, 1'b1, 2'b00);
    req = 2'b00;
    tick(); expect_o("abort", 2'b00, 4'd0, 1'b0, 2'b00);
    tick(); expect_o("abort_hold", 2'b00, 4'd0, 1'b0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
